// File: rtl/scan_ctrl_165.sv
// rtl/scan_ctrl_165.sv - scan sequencer for a cascaded 74LS165 parallel-in/serial-out chain
// Loads the chain, shifts it at one bit per DIV clocks and publishes the assembled word.
module scan_ctrl_165 #(
  parameter int WIDTH = 16,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             auto_en,
  input  logic             sr_qh,
  output logic             sr_shld_n,
  output logic             sr_clk_inh,
  output logic             busy,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             data_changed
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BLAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DLAST = DW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic [WIDTH-2:0] cap_q, cap_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             valid_q, valid_d;
  logic             changed_q, changed_d;
  logic             shld_n_q, shld_n_d;
  logic             clk_inh_q, clk_inh_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] cap_shift;

  // The MSB of the shifted value only exists on the final sample, where it becomes data_out.
  assign cap_shift = {cap_q, sr_qh};

  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    dcnt_d     = dcnt_q;
    cap_d      = cap_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    changed_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start || auto_en) state_d = LOAD;
      end
      LOAD: begin
        state_d = SHIFT;
        bcnt_d  = '0;
        dcnt_d  = '0;
      end
      SHIFT: begin
        if (dcnt_q == DLAST) begin
          cap_d  = cap_shift[WIDTH-2:0];
          dcnt_d = '0;
          if (bcnt_q == BLAST) begin
            data_out_d = cap_shift;
            valid_d    = 1'b1;
            changed_d  = (cap_shift != data_out_q);
            bcnt_d     = '0;
            state_d    = IDLE;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Chain controls are registered from next-state values so they track state/counters exactly.
    shld_n_d  = (state_d != LOAD);
    clk_inh_d = !((state_d == SHIFT) && (dcnt_d == DLAST) && (bcnt_d != BLAST));
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bcnt_q     <= '0;
      dcnt_q     <= '0;
      cap_q      <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      changed_q  <= 1'b0;
      shld_n_q   <= 1'b1;
      clk_inh_q  <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      dcnt_q     <= dcnt_d;
      cap_q      <= cap_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      changed_q  <= changed_d;
      shld_n_q   <= shld_n_d;
      clk_inh_q  <= clk_inh_d;
      busy_q     <= busy_d;
    end
  end

  assign sr_shld_n    = shld_n_q;
  assign sr_clk_inh   = clk_inh_q;
  assign busy         = busy_q;
  assign data_out     = data_out_q;
  assign data_valid   = valid_q;
  assign data_changed = changed_q;

endmodule

// File: tb/tb_scan_ctrl_165.sv
// tb/tb_scan_ctrl_165.sv - self-checking bench for scan_ctrl_165 with a two-stage 74LS165 chain model
// Instance a uses the defaults (DIV=4); instance b uses DIV=1.
module tb_scan_ctrl_165;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   s;

  logic start_a = 1'b0, auto_en_a = 1'b0, start_b = 1'b0, auto_en_b = 1'b0;
  logic sr_qh_a, sr_shld_n_a, sr_clk_inh_a, busy_a, data_valid_a, data_changed_a;
  logic sr_qh_b, sr_shld_n_b, sr_clk_inh_b, busy_b, data_valid_b, data_changed_b;
  logic [15:0] data_out_a, data_out_b;

  logic [7:0] p0a = 8'h00, p1a = 8'h00, s0a = 8'h00, s1a = 8'h00;
  logic [7:0] p0b = 8'h00, p1b = 8'h00, s0b = 8'h00, s1b = 8'h00;

  logic [16:0] q_a[$];
  logic [16:0] q_b[$];
  int load_a[$], inh_a[$], valid_a[$];
  int load_b[$], inh_b[$], valid_b[$];
  logic [16:0] e_a, e_b;

  scan_ctrl_165 #(.WIDTH(16), .DIV(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .auto_en(auto_en_a), .sr_qh(sr_qh_a),
    .sr_shld_n(sr_shld_n_a), .sr_clk_inh(sr_clk_inh_a), .busy(busy_a),
    .data_out(data_out_a), .data_valid(data_valid_a), .data_changed(data_changed_a)
  );

  scan_ctrl_165 #(.WIDTH(16), .DIV(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .auto_en(auto_en_b), .sr_qh(sr_qh_b),
    .sr_shld_n(sr_shld_n_b), .sr_clk_inh(sr_clk_inh_b), .busy(busy_b),
    .data_out(data_out_b), .data_valid(data_valid_b), .data_changed(data_changed_b)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Chain model: stage 0 drives QH, stage 1 feeds stage 0's SER, load has priority over shift.
  assign sr_qh_a = s0a[7];
  assign sr_qh_b = s0b[7];

  always @(posedge clk) begin
    if (!sr_shld_n_a) begin
      s0a <= p0a;
      s1a <= p1a;
    end else if (!sr_clk_inh_a) begin
      s0a <= {s0a[6:0], s1a[7]};
      s1a <= {s1a[6:0], 1'b0};
    end
    if (!sr_shld_n_b) begin
      s0b <= p0b;
      s1b <= p1b;
    end else if (!sr_clk_inh_b) begin
      s0b <= {s0b[6:0], s1b[7]};
      s1b <= {s1b[6:0], 1'b0};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    load_a.delete(); inh_a.delete(); valid_a.delete();
    load_b.delete(); inh_b.delete(); valid_b.delete();
  endtask

  always @(negedge clk) begin
    if (sr_shld_n_a === 1'b0) load_a.push_back(cyc);
    if (sr_clk_inh_a === 1'b0) inh_a.push_back(cyc);
    if (data_valid_a === 1'b1) begin
      valid_a.push_back(cyc);
      check("sb_nonempty_a", 32'(q_a.size() > 0), 1);
      if (q_a.size() > 0) begin
        e_a = q_a.pop_front();
        check("data_out_a", 32'(data_out_a), 32'(e_a[15:0]));
        check("data_changed_a", 32'(data_changed_a), 32'(e_a[16]));
        check("busy_at_valid_a", 32'(busy_a), 0);
      end
    end
    if (sr_shld_n_b === 1'b0) load_b.push_back(cyc);
    if (sr_clk_inh_b === 1'b0) inh_b.push_back(cyc);
    if (data_valid_b === 1'b1) begin
      valid_b.push_back(cyc);
      check("sb_nonempty_b", 32'(q_b.size() > 0), 1);
      if (q_b.size() > 0) begin
        e_b = q_b.pop_front();
        check("data_out_b", 32'(data_out_b), 32'(e_b[15:0]));
        check("data_changed_b", 32'(data_changed_b), 32'(e_b[16]));
      end
    end
  end

  initial begin
    // Asynchronous reset with the clock stopped
    #3 rst = 1'b1;
    #1;
    check("rst_shld_n_a", 32'(sr_shld_n_a), 1);
    check("rst_clk_inh_a", 32'(sr_clk_inh_a), 1);
    check("rst_busy_a", 32'(busy_a), 0);
    check("rst_data_out_a", 32'(data_out_a), 0);
    check("rst_valid_a", 32'(data_valid_a), 0);
    check("rst_changed_a", 32'(data_changed_a), 0);
    check("rst_shld_n_b", 32'(sr_shld_n_b), 1);
    check("rst_clk_inh_b", 32'(sr_clk_inh_b), 1);
    check("rst_data_out_b", 32'(data_out_b), 0);
    #6 clk_en = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single scan, defaults
    clear_logs();
    p0a = 8'hA5; p1a = 8'h3C;
    q_a.push_back({1'b1, 16'hA53C});
    s = cyc; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    repeat (74) @(negedge clk);
    #1;
    check("load_count", 32'(load_a.size()), 1);
    if (load_a.size() > 0) check("load_cycle", 32'(load_a[0] - s), 1);
    check("inh_count", 32'(inh_a.size()), 15);
    if (inh_a.size() > 0) check("inh_first", 32'(inh_a[0] - s), 5);
    for (int i = 1; i < inh_a.size(); i++) check("inh_spacing", 32'(inh_a[i] - inh_a[i-1]), 4);
    check("valid_count", 32'(valid_a.size()), 1);
    if (valid_a.size() > 0) check("valid_latency", 32'(valid_a[0] - s), 66);
    check("valid_low_after", 32'(data_valid_a), 0);

    // start held high during the scan is ignored
    clear_logs();
    q_a.push_back({1'b0, 16'hA53C});
    s = cyc; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    repeat (9) @(negedge clk); start_a = 1'b1;
    repeat (31) @(negedge clk); start_a = 1'b0;
    repeat (34) @(negedge clk);
    #1;
    check("held_load_count", 32'(load_a.size()), 1);
    check("held_valid_count", 32'(valid_a.size()), 1);
    if (valid_a.size() > 0) check("held_valid_latency", 32'(valid_a[0] - s), 66);
    check("held_busy_end", 32'(busy_a), 0);

    // Reset mid-scan aborts it
    clear_logs();
    s = cyc; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    repeat (29) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_data_out", 32'(data_out_a), 0);
    check("abort_shld_n", 32'(sr_shld_n_a), 1);
    check("abort_clk_inh", 32'(sr_clk_inh_a), 1);
    check("abort_busy", 32'(busy_a), 0);
    @(negedge clk); rst = 1'b0;
    check("abort_no_valid", 32'(valid_a.size()), 0);
    clear_logs();
    q_a.push_back({1'b1, 16'hA53C});
    s = cyc; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    repeat (74) @(negedge clk);
    #1;
    check("post_abort_valid_count", 32'(valid_a.size()), 1);
    if (valid_a.size() > 0) check("post_abort_latency", 32'(valid_a[0] - s), 66);

    // auto_en back-to-back scans after a fresh reset
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    clear_logs();
    q_a.push_back({1'b1, 16'hA53C});
    q_a.push_back({1'b0, 16'hA53C});
    q_a.push_back({1'b0, 16'hA53C});
    s = cyc; auto_en_a = 1'b1;
    repeat (190) @(negedge clk); auto_en_a = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    check("auto_load_count", 32'(load_a.size()), 3);
    if (load_a.size() > 0) check("auto_first_load", 32'(load_a[0] - s), 1);
    for (int i = 1; i < load_a.size(); i++) check("auto_period", 32'(load_a[i] - load_a[i-1]), 66);
    check("auto_valid_count", 32'(valid_a.size()), 3);
    check("auto_sb_drained", 32'(q_a.size()), 0);

    // DIV=1 instance
    clear_logs();
    p0b = 8'hFF; p1b = 8'hFF;
    q_b.push_back({1'b1, 16'hFFFF});
    s = cyc; start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    repeat (24) @(negedge clk);
    #1;
    check("div1_valid_count", 32'(valid_b.size()), 1);
    if (valid_b.size() > 0) check("div1_latency", 32'(valid_b[0] - s), 18);
    check("div1_inh_count", 32'(inh_b.size()), 15);
    if (inh_b.size() > 0) begin
      check("div1_inh_first", 32'(inh_b[0] - s), 2);
      check("div1_inh_consecutive", 32'(inh_b[inh_b.size()-1] - inh_b[0]), 14);
    end

    clear_logs();
    q_b.push_back({1'b0, 16'hFFFF});
    start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    repeat (24) @(negedge clk);

    p0b = 8'h7F;
    q_b.push_back({1'b1, 16'h7FFF});
    start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    repeat (24) @(negedge clk);
    #1;
    check("div1_rescan_valid_count", 32'(valid_b.size()), 2);
    check("div1_sb_drained", 32'(q_b.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
